// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite encodings and slave state type for the descriptor memory
// responder and its memory sub-module.
//   HTRANS_*      : transfer type encodings
//   HSIZE_WORD    : the only transfer size the responder accepts
//   HRESP_*       : response encodings
//   slv_state_t   : responder FSM states
//   DESC_WORDS    : words per linked-list descriptor (next pointer + 5 payload)
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_t;

    localparam int DESC_WORDS = 6;

endpackage

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem
// DEPTH x 32 descriptor storage.
//   clk, rst_n        : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata    : bus write port, commits at the clock edge
//   ld_en/ld_addr/ld_data : backdoor write port, wins over a bus write to the
//                       same index in the same cycle
//   re/raddr          : registered read request; rdata updates at the edge
//   clr               : forces rdata to zero at the edge (writes and errors)
//   rdata             : registered read data
// The array itself is never reset.
module ahb_slv_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          clr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (we && !(ld_en && (ld_addr == waddr))) begin
            mem[waddr] <= wdata;
        end
    end

    // A read sampled on the same edge as a write to the same index must see
    // the value that edge stores, so forward it in the same priority order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            if (ld_en && (ld_addr == raddr)) begin
                rdata <= ld_data;
            end else if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/ahb_desc_mem_slave.sv
// ahb_desc_mem_slave
// AHB-Lite responder for the linked-list descriptor memory walked by the
// bitmove bridge master. Single 32-bit word reads/writes, fixed wait states,
// two-cycle ERROR on illegal accesses, and a backdoor load port.
//   HCLK, HRESETn     : clock, asynchronous active-low reset
//   HSEL..HREADY      : AHB-Lite address/data phase inputs
//   HREADYOUT, HRESP, HRDATA : registered slave responses
//   ld_en/ld_addr/ld_data : backdoor word write, independent of the bus
//   dbg_state         : current FSM state (slv_state_t encoding)
// Build option: define AHB_SLV_RANDWAIT_EN to add 0..3 pseudo-random wait
// states (16-bit LFSR) on top of WAIT_CNT for every valid transfer.
module ahb_desc_mem_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          WAIT_CNT  = 0,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic [1:0]    dbg_state
);

    localparam int            CW      = 4;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    slv_state_t    state;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic [AW-1:0] idx_q;

    logic          done;
    logic          slot_free;
    logic          cap;
    logic          cap_err;
    logic          in_range;
    logic [AW-1:0] cap_idx;
    logic [1:0]    extra_wait;
    logic [CW-1:0] cap_wait;

    logic          mem_we;
    logic          mem_re;
    logic          mem_clr;
    logic [AW-1:0] mem_raddr;

    // Handshake: an address phase is accepted on the edge where HSEL, HREADY
    // and a NONSEQ/SEQ HTRANS are all high and this responder has no data
    // phase still stalling. The data phase then completes on the first cycle
    // HREADYOUT is high; HRESP/HRDATA are only meaningful on that cycle.
    assign done      = (state == ST_DATA) && (cnt == '0);
    assign slot_free = (state == ST_IDLE) || (state == ST_ERR2) || done;
    assign cap       = HSEL && HREADY && slot_free &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // BASE_ADDR is DEPTH*4 aligned, so the window check is an upper-bit match.
    assign in_range = (HADDR[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign cap_idx  = HADDR[AW+1:2];
    assign cap_err  = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00) || !in_range;

`ifdef AHB_SLV_RANDWAIT_EN
    logic [15:0] lfsr;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, free-running.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign extra_wait = lfsr[1:0];
`else
    assign extra_wait = 2'b00;
`endif

    assign cap_wait = CW'(WAIT_CNT) + {2'b00, extra_wait};

    // Memory commits on the completing edge of a write data phase.
    assign mem_we = done && wr_q;

    // Read data is loaded on the edge that enters the completing cycle: the
    // capture edge itself for zero-wait reads, else the last wait edge.
    assign mem_re    = (cap && !cap_err && !HWRITE && (cap_wait == '0)) ||
                       ((state == ST_DATA) && (cnt == CNT_ONE) && !wr_q);
    assign mem_raddr = ((state == ST_DATA) && (cnt != '0)) ? idx_q : cap_idx;
    assign mem_clr   = cap && (cap_err || HWRITE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else if ((state == ST_DATA) && (cnt != '0)) begin
            cnt       <= cnt - CNT_ONE;
            HREADYOUT <= (cnt == CNT_ONE);
        end else if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_ERROR;
        end else if (cap) begin
            wr_q  <= HWRITE;
            idx_q <= cap_idx;
            if (cap_err) begin
                state     <= ST_ERR1;
                cnt       <= '0;
                HREADYOUT <= 1'b0;
                HRESP     <= HRESP_ERROR;
            end else begin
                state     <= ST_DATA;
                cnt       <= cap_wait;
                HREADYOUT <= (cap_wait == '0);
                HRESP     <= HRESP_OKAY;
            end
        end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end
    end

    assign dbg_state = state;

    ahb_slv_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .we      (mem_we),
        .waddr   (idx_q),
        .wdata   (HWDATA),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .re      (mem_re),
        .raddr   (mem_raddr),
        .clr     (mem_clr),
        .rdata   (HRDATA)
    );

endmodule

// File: tb/tb_ahb_desc_mem_slave.sv
// tb_ahb_desc_mem_slave
// Directed bench for ahb_desc_mem_slave. Two instances share the bus inputs:
// dut0 (WAIT_CNT=0) and dut3 (WAIT_CNT=3); `sel` steers HSEL to one of them.
module tb_ahb_desc_mem_slave;
    import ahb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- bus and backdoor signals ----------------
    logic        hsel, hwrite, hready_block;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    int          sel;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    logic        hsel0, hsel3, hready0, hready3;
    logic        hreadyout0, hreadyout3, hresp0, hresp3;
    logic [31:0] hrdata0, hrdata3;
    logic [1:0]  st0, st3;

    logic        ro_ready, ro_resp;
    logic [31:0] ro_rdata;
    logic [1:0]  ro_state;

    assign hsel0    = hsel && (sel == 0);
    assign hsel3    = hsel && (sel == 1);
    assign hready0  = hreadyout0 && !hready_block;
    assign hready3  = hreadyout3;
    assign ro_ready = (sel == 0) ? hreadyout0 : hreadyout3;
    assign ro_resp  = (sel == 0) ? hresp0 : hresp3;
    assign ro_rdata = (sel == 0) ? hrdata0 : hrdata3;
    assign ro_state = (sel == 0) ? st0 : st3;

    ahb_desc_mem_slave #(.BASE_ADDR(32'h0), .DEPTH(256), .WAIT_CNT(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
        .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_state(st0)
    );

    ahb_desc_mem_slave #(.BASE_ADDR(32'h0), .DEPTH(256), .WAIT_CNT(3)) dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready3),
        .HREADYOUT(hreadyout3), .HRESP(hresp3), .HRDATA(hrdata3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_state(st3)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] chain [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic backdoor(input logic [7:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // One isolated transfer; waits counts data-phase cycles with HREADYOUT low.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int waits, output logic resp);
        addr_phase(wr, a, sz);
        tick();
        bus_idle();
        hwdata = wd;
        waits  = 0;
        while (ro_ready !== 1'b1 && waits < 40) begin
            waits++;
            tick();
        end
        rd   = ro_rdata;
        resp = ro_resp;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int          w;
        logic        r;
        int          idx;

        chain[0] = 32'h18; chain[1] = 32'h1; chain[2] = 32'h2;
        chain[3] = 32'h3;  chain[4] = 32'h4; chain[5] = 32'h5;

        rst_n = 1'b0; sel = 0; hready_block = 1'b0;
        bus_idle();
        haddr = '0; hsize = HSIZE_WORD; hwdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        chk("rst_ready0", {31'd0, hreadyout0}, 32'd1);
        chk("rst_resp0",  {31'd0, hresp0},     32'd0);
        chk("rst_rdata0", hrdata0,             32'd0);
        chk("rst_state0", {30'd0, st0},        32'd0);
        chk("rst_ready3", {31'd0, hreadyout3}, 32'd1);
        chk("rst_rdata3", hrdata3,             32'd0);
        rst_n = 1'b1;
        tick();

        // backdoor chain load (both instances)
        for (int i = 0; i < 6; i++) backdoor(8'(i), chain[i]);

        // zero-wait read
        sel = 0;
        xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, w, r);
        chk("rd0_data", rd, 32'h18);
        chk("rd0_waits", 32'(w), 32'd0);
        chk("rd0_resp", {31'd0, r}, 32'd0);
        chk("rd0_hold", ro_rdata, 32'h18);

        // back-to-back write then read same index (bypass)
        addr_phase(1'b1, 32'h10, HSIZE_WORD);
        tick();
        hwdata = 32'hDEAD_BEEF;
        addr_phase(1'b0, 32'h10, HSIZE_WORD);
        chk("b2b_wr_ready", {31'd0, ro_ready}, 32'd1);
        chk("b2b_wr_rdata0", ro_rdata, 32'd0);
        tick();
        bus_idle();
        chk("b2b_rd_ready", {31'd0, ro_ready}, 32'd1);
        chk("b2b_rd_resp", {31'd0, ro_resp}, 32'd0);
        chk("b2b_rd_bypass", ro_rdata, 32'hDEAD_BEEF);
        tick();

        // back-to-back write then read of a different index
        addr_phase(1'b1, 32'h10, HSIZE_WORD);
        tick();
        hwdata = 32'h0000_CAFE;
        addr_phase(1'b0, 32'h14, HSIZE_WORD);
        tick();
        bus_idle();
        chk("b2b_other_idx", ro_rdata, 32'h5);
        tick();
        xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, w, r);
        chk("wr_committed", rd, 32'h0000_CAFE);

        // three wait states
        sel = 1;
        xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, w, r);
        chk("wait3_data", rd, 32'h1);
        chk("wait3_waits", 32'(w), 32'd3);
        chk("wait3_resp", {31'd0, r}, 32'd0);

        // out-of-window read -> two-cycle ERROR, then a write from ERR2
        sel = 0;
        addr_phase(1'b0, 32'h400, HSIZE_WORD);
        tick();
        bus_idle();
        chk("err1_ready", {31'd0, ro_ready}, 32'd0);
        chk("err1_resp", {31'd0, ro_resp}, 32'd1);
        chk("err1_rdata", ro_rdata, 32'd0);
        tick();
        chk("err2_ready", {31'd0, ro_ready}, 32'd1);
        chk("err2_resp", {31'd0, ro_resp}, 32'd1);
        addr_phase(1'b1, 32'h8, HSIZE_WORD);
        tick();
        bus_idle();
        hwdata = 32'h7;
        chk("post_err_wr_ready", {31'd0, ro_ready}, 32'd1);
        chk("post_err_wr_resp", {31'd0, ro_resp}, 32'd0);
        tick();
        xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, w, r);
        chk("post_err_rd", rd, 32'h7);

        xfer(1'b0, 32'h8, 3'b001, 32'h0, rd, w, r);
        chk("hsize_err_waits", 32'(w), 32'd1);
        chk("hsize_err_resp", {31'd0, r}, 32'd1);
        xfer(1'b0, 32'h2, HSIZE_WORD, 32'h0, rd, w, r);
        chk("misalign_err_resp", {31'd0, r}, 32'd1);
        xfer(1'b0, 32'h3FC, HSIZE_WORD, 32'h0, rd, w, r);
        chk("last_word_okay", {31'd0, r}, 32'd0);

        // reset during a write data phase
        addr_phase(1'b1, 32'hC, HSIZE_WORD);
        tick();
        bus_idle();
        hwdata = 32'h0000_0BAD;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ro_ready}, 32'd1);
        chk("midrst_resp", {31'd0, ro_resp}, 32'd0);
        chk("midrst_rdata", ro_rdata, 32'd0);
        chk("midrst_state", {30'd0, ro_state}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        xfer(1'b0, 32'hC, HSIZE_WORD, 32'h0, rd, w, r);
        chk("midrst_no_commit", rd, 32'h3);

        // backdoor beats a bus write to the same index
        addr_phase(1'b1, 32'h18, HSIZE_WORD);
        tick();
        bus_idle();
        hwdata  = 32'hAAAA_AAAA;
        ld_en   = 1'b1;
        ld_addr = 8'd6;
        ld_data = 32'h5555_5555;
        tick();
        ld_en = 1'b0;
        xfer(1'b0, 32'h18, HSIZE_WORD, 32'h0, rd, w, r);
        chk("ld_priority", rd, 32'h5555_5555);

        // HREADY low with HSEL high: no capture
        hready_block = 1'b1;
        addr_phase(1'b0, 32'h0, HSIZE_WORD);
        tick();
        bus_idle();
        chk("hready_low_state", {30'd0, ro_state}, 32'd0);
        chk("hready_low_ready", {31'd0, ro_ready}, 32'd1);
        hready_block = 1'b0;
        tick();

        // random reads over the chain on the wait-state instance
        sel = 1;
        for (int n = 0; n < 100; n++) begin
            idx = $urandom_range(0, 5);
            exp_q.push_back(chain[idx]);
            xfer(1'b0, 32'(idx * 4), HSIZE_WORD, 32'h0, rd, w, r);
            chk("rand_rd_data", rd, exp_q.pop_front());
`ifdef AHB_SLV_RANDWAIT_EN
            chk("rand_wait_range", {31'd0, (w >= 3 && w <= 6)}, 32'd1);
`else
            chk("rand_wait_exact", 32'(w), 32'd3);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_desc_mem_slave.md
Name: ahb_desc_mem_slave

Overview:
AHB-Lite responder holding the linked-list descriptor memory that the bitmove bridge master walks. Each descriptor is six words: word 0 is the next pointer, words 1..5 are the payload.
- Services single word reads and writes with configurable wait states.
- Returns ERROR on illegal accesses.
- Has a backdoor load port so benches can prebuild descriptor chains.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the window; must be DEPTH*4 aligned
DEPTH, 256, number of 32-bit words
WAIT_CNT, 0, fixed wait states inserted per valid transfer (0..7)

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  transfer size; only 3'b010 is legal
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-level ready; address phase accepted only when high
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY 1=ERROR
HRDATA  out  32  read data
ld_en  in  1  backdoor write strobe
ld_addr  in  $clog2(DEPTH)  backdoor word index
ld_data  in  32  backdoor data

Behaviour:
- Reset values (HRESETn low, async): HREADYOUT=1, HRESP=0, HRDATA=0, state=ST_IDLE, wait counter=0, captured controls cleared. Memory contents are not reset.
- Address-phase capture: occurs when HSEL & HREADY & HTRANS[1]. Capture write flag, word index (HADDR-BASE_ADDR)>>2, and an error flag.
- Error flag is set when any of: HSIZE!=010; HADDR[1:0]!=0; HADDR outside [BASE_ADDR, BASE_ADDR+DEPTH*4).
- IDLE/BUSY or HSEL low: no capture; the next cycle is zero-wait OKAY.
- States:
  - ST_IDLE: no pending data phase; HREADYOUT=1, HRESP=0. Valid capture -> ST_DATA, or ST_ERR1 if the error flag is set.
  - ST_DATA: counter loads WAIT_CNT on capture; HREADYOUT=(cnt==0); cnt decrements while nonzero. When cnt==0 the transfer completes this cycle.
    - Read: HRDATA = mem[idx], registered so it is valid on the completing cycle.
    - Write: HWDATA is written to mem[idx] at the completing edge.
    - If a new valid capture occurs on the completing cycle (pipelined back-to-back), go to ST_DATA/ST_ERR1 again; otherwise go to ST_IDLE.
  - ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1. No memory access. Capture allowed -> ST_DATA/ST_ERR1/ST_IDLE.
- Latency: WAIT_CNT=0 gives a one-cycle data phase, and back-to-back NONSEQ sustains one transfer per cycle.
- Read-after-write hazard: a read whose data phase immediately follows a write to the same index must return the new HWDATA (bypass). A read to a different index is unaffected.
- HRDATA holds its last value when no read completes. On writes and errors it drives 0.
- Backdoor: ld_en writes mem[ld_addr] at the edge. It has priority over a bus write to the same index in the same cycle, and is ignored for bus protocol purposes.
- HREADY low with HSEL high: no capture, state unaffected.
- Reset mid-transfer: the pending data phase is abandoned and no write is committed.

Optional Feature:
Macro AHB_SLV_RANDWAIT_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle. Each captured valid transfer adds lfsr[1:0] (0..3) extra wait states on top of WAIT_CNT. Error responses are unaffected.
- Undefined: wait states are exactly WAIT_CNT and no LFSR logic exists.

Decomposition:
- Package ahb_pkg:
  - HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE_WORD
  - HRESP_OKAY/HRESP_ERROR
  - slave state enum (ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2)
  - DESC_WORDS=6
- One sub-module, ahb_slv_mem: DEPTH x 32 array with a single bus write port, a backdoor write port with priority, and a registered read port with the write-bypass.

Test Plan:
- Backdoor-load mem[0]=32'h18, mem[1..5]=1..5; bus NONSEQ read 0x0, WAIT_CNT=0 -> HRDATA=32'h18 next cycle, HREADYOUT=1, HRESP=0.
- Back-to-back NONSEQ write 0x10=32'hDEAD_BEEF then read 0x10 -> read returns 32'hDEAD_BEEF with zero waits (bypass).
- WAIT_CNT=3, read 0x4 -> HREADYOUT low exactly 3 cycles, then data 32'h1.
- Read at BASE_ADDR+DEPTH*4 (0x400), or HSIZE=001 at 0x8 -> two-cycle ERROR (HREADYOUT 0/1, HRESP 1/1); following write 0x8=7 completes OKAY.
- Write 0xC with HRESETn asserted during its data phase -> after reset a read of 0xC returns the old contents; outputs are at reset values during reset.
- With AHB_SLV_RANDWAIT_EN, 100 random reads over the chain -> every read returns the loaded data, and the per-transfer wait count is within WAIT_CNT..WAIT_CNT+3.
